// File: rtl/boot_loader.sv
// Loads a length-prefixed little-endian image from a valid/ready byte stream into
// instruction memory, then releases the core. Trailing checksum byte: BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
    parameter int WORD_NUM    = 256,
    parameter int RELEASE_DLY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic [31:0] Inst_addr_load,
    output logic [31:0] Inst_load,
    output logic        load_en,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

`ifdef BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHK, S_WAIT, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_WAIT, S_RUN, S_ERR} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [15:0] r_dly_cnt;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic        r_byte_ready;
    logic        r_load_en;
    logic        r_core_rst_n;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_accept;
    logic        w_word_done;
    logic        w_last_word;
    logic        w_next_ready;
    logic [15:0] w_len;

    assign w_accept     = byte_valid && r_byte_ready;
    assign w_len        = {byte_data, r_len[7:0]};
    assign w_last_word  = (r_word_idx == r_len - 16'd1);
    assign w_word_done  = (r_state == S_DATA) && w_accept && (r_byte_cnt == 2'd3);
    assign w_next_ready = !(w_next inside {S_WAIT, S_RUN});

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN0: if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if ({16'd0, w_len} > 32'(WORD_NUM)) w_next = S_ERR;
                    else if (w_len == 16'd0)            w_next = S_WAIT;
                    else                                w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_done && w_last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_WAIT;
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: if (w_accept) w_next = (byte_data == r_sum) ? S_WAIT : S_ERR;
`endif
            S_WAIT: if (r_dly_cnt == 16'(RELEASE_DLY - 1)) w_next = S_RUN;
            S_RUN:  w_next = S_RUN;
            S_ERR:  w_next = S_ERR;
            default: w_next = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_word_idx   <= '0;
            r_dly_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_byte_ready <= 1'b0;
            r_load_en    <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_inst       <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            if (w_accept && r_state == S_LEN0) r_len[7:0]  <= byte_data;
            if (w_accept && r_state == S_LEN1) r_len[15:8] <= byte_data;

            if (w_accept && r_state == S_DATA) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                r_sum      <= r_sum + byte_data;
`endif
                case (r_byte_cnt)
                    2'd0:    r_word[7:0]   <= byte_data;
                    2'd1:    r_word[15:8]  <= byte_data;
                    2'd2:    r_word[23:16] <= byte_data;
                    default: r_word        <= r_word;
                endcase
            end

            // The top byte goes straight into the output word; no 4th staging byte is needed.
            r_load_en <= w_word_done;
            if (w_word_done) begin
                r_inst     <= {byte_data, r_word};
                r_addr     <= {14'd0, r_word_idx, 2'b00};
                r_word_idx <= r_word_idx + 16'd1;
            end

            r_dly_cnt    <= (r_state == S_WAIT) ? r_dly_cnt + 16'd1 : 16'd0;
            r_byte_ready <= w_next_ready;
            r_core_rst_n <= (w_next == S_RUN);
            r_done       <= (w_next == S_RUN);
            r_err        <= r_err || (w_next == S_ERR);
        end
    end

    assign byte_ready     = r_byte_ready;
    assign load_en        = r_load_en;
    assign Inst_addr_load = r_addr;
    assign Inst_load      = r_inst;
    assign core_rst_n     = r_core_rst_n;
    assign done           = r_done;
    assign err            = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random images and handshake gaps compared against
// an image-level model of the expected writes, error and release timing.
module tb_boot_loader;

    localparam int WORD_NUM    = 256;
    localparam int RELEASE_DLY = 2;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] Inst_addr_load;
    logic [31:0] Inst_load;
    logic        load_en;
    logic        core_rst_n;
    logic        done;
    logic        err;

    boot_loader #(.WORD_NUM(WORD_NUM), .RELEASE_DLY(RELEASE_DLY)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .Inst_addr_load (Inst_addr_load),
        .Inst_load      (Inst_load),
        .load_en        (load_en),
        .core_rst_n     (core_rst_n),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Event recorder: write strobes and rising edges of core_rst_n / err, tagged by cycle.
    logic [31:0] se_addr[$];
    logic [31:0] se_data[$];
    int          se_cyc[$];
    int          rise_q[$];
    int          err_q[$];
    logic        prev_core = 1'b0;
    logic        prev_err  = 1'b0;

    always @(negedge clk) begin
        if (load_en) begin
            se_addr.push_back(Inst_addr_load);
            se_data.push_back(Inst_load);
            se_cyc.push_back(cyc);
        end
        if (core_rst_n && !prev_core) rise_q.push_back(cyc);
        if (err && !prev_err) err_q.push_back(cyc);
        prev_core = core_rst_n;
        prev_err  = err;
    end

    logic [7:0]  img[$];
    int          gaps[$];
    int          acc[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic build_img(input int len, input int gmax, input bit bad);
        logic [7:0] sum;
        logic [7:0] b;
        img.delete();
        gaps.delete();
        sum = 8'd0;
        img.push_back(len[7:0]);
        img.push_back(len[15:8]);
        if (len > WORD_NUM) begin
            repeat (5) img.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                sum = sum + b;
                img.push_back(b);
            end
            if (bad) sum = sum + 8'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            if (len > 0) img.push_back(sum);
`endif
        end
        for (int i = 0; i < img.size(); i++) gaps.push_back(int'($urandom_range(0, gmax)));
    endtask

    // Image-level reference: which words get written, whether the load fails, and which
    // byte index (trig) is the one that ends loading (release countdown or error).
    task automatic model(output int n_words, output bit exp_err, output int trig);
        int len;
        int base;
        logic [7:0] sum;
        len = int'(img[0]) + 256 * int'(img[1]);
        exp_addr.delete();
        exp_data.delete();
        sum = 8'd0;
        if (len > WORD_NUM) begin
            n_words = 0;
            exp_err = 1'b1;
            trig    = 1;
        end else begin
            n_words = len;
            exp_err = 1'b0;
            for (int i = 0; i < len; i++) begin
                base = 2 + 4 * i;
                exp_addr.push_back(32'(i * 4));
                exp_data.push_back({img[base + 3], img[base + 2], img[base + 1], img[base]});
                for (int k = 0; k < 4; k++) sum = sum + img[base + k];
            end
            trig = 1 + 4 * len;
`ifdef BOOT_LOADER_CHECKSUM_EN
            if (len > 0) begin
                trig    = trig + 1;
                exp_err = (img[trig] != sum);
            end
`endif
        end
    endtask

    task automatic send_img(input int n);
        bit ok;
        acc.delete();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                byte_valid = 1'b0;
                @(posedge clk);
            end
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                @(negedge clk);
                byte_valid = 1'b1;
                byte_data  = img[i];
                if (byte_ready) begin
                    ok = 1'b1;
                    acc.push_back(cyc);
                end
                @(posedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL handshake byte %0d: byte_ready stayed 0, expected acceptance within 64 cycles", i);
                acc.push_back(-1);
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic apply_reset(input string name);
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        #1;
        checks++;
        if ({byte_ready, Inst_addr_load, Inst_load, load_en, core_rst_n, done, err} !== 69'd0) begin
            errors++;
            $display("FAIL %s reset_values: ready=%b addr=%h data=%h load_en=%b core_rst_n=%b done=%b err=%b, expected all 0",
                     name, byte_ready, Inst_addr_load, Inst_load, load_en, core_rst_n, done, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_reset: got %b expected 1", name, byte_ready);
        end
    endtask

    task automatic run_image(input string name);
        int n;
        int trig;
        int s0;
        int r0;
        int e0;
        int got;
        bit xerr;
        model(n, xerr, trig);
        s0 = se_cyc.size();
        r0 = rise_q.size();
        e0 = err_q.size();
        send_img(img.size());
        repeat (RELEASE_DLY + 6) @(negedge clk);
        #1;
        got = se_cyc.size() - s0;
        checks++;
        if (got !== n) begin
            errors++;
            $display("FAIL %s strobe_count: got %0d expected %0d", name, got, n);
        end
        for (int i = 0; i < n && i < got; i++) begin
            checks++;
            if (se_addr[s0 + i] !== exp_addr[i] || se_data[s0 + i] !== exp_data[i] ||
                se_cyc[s0 + i] !== acc[2 + 4 * i + 3] + 1) begin
                errors++;
                $display("FAIL %s word%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                         name, i, se_addr[s0 + i], se_data[s0 + i], se_cyc[s0 + i],
                         exp_addr[i], exp_data[i], acc[2 + 4 * i + 3] + 1);
            end
        end
        checks++;
        if ({err, done, core_rst_n, byte_ready} !== {xerr, !xerr, !xerr, xerr}) begin
            errors++;
            $display("FAIL %s final_status: got err/done/core_rst_n/ready=%b%b%b%b expected %b%b%b%b",
                     name, err, done, core_rst_n, byte_ready, xerr, !xerr, !xerr, xerr);
        end
        checks++;
        if (!xerr) begin
            if (rise_q.size() - r0 != 1) begin
                errors++;
                $display("FAIL %s release_edges: got %0d expected 1", name, rise_q.size() - r0);
            end else if (rise_q[r0] != acc[trig] + 1 + RELEASE_DLY) begin
                errors++;
                $display("FAIL %s release_cycle: got %0d expected %0d", name, rise_q[r0], acc[trig] + 1 + RELEASE_DLY);
            end
        end else begin
            if (err_q.size() - e0 != 1 || rise_q.size() != r0) begin
                errors++;
                $display("FAIL %s err_edges: got err=%0d release=%0d expected 1 and 0",
                         name, err_q.size() - e0, rise_q.size() - r0);
            end else if (err_q[e0] != acc[trig] + 1) begin
                errors++;
                $display("FAIL %s err_cycle: got %0d expected %0d", name, err_q[e0], acc[trig] + 1);
            end
        end
        if (n > 0) begin
            checks++;
            if (Inst_addr_load !== exp_addr[n - 1] || Inst_load !== exp_data[n - 1]) begin
                errors++;
                $display("FAIL %s held_outputs: got addr=%h data=%h expected addr=%h data=%h",
                         name, Inst_addr_load, Inst_load, exp_addr[n - 1], exp_data[n - 1]);
            end
        end
    endtask

    task automatic set_directed(input logic [7:0] chk);
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
        img.push_back(chk);
`else
        if (chk == 8'hFF) img.push_back(chk);
`endif
        gaps.delete();
        for (int i = 0; i < img.size(); i++) gaps.push_back(0);
    endtask

    task automatic test_two_words();
        set_directed(8'hD6);
        run_image("two_words");
        #2;
        apply_reset("reset_from_run");
    endtask

    task automatic test_len_overflow();
        build_img(WORD_NUM + 1, 1, 1'b0);
        run_image("len_overflow");
        apply_reset("after_overflow");
    endtask

    task automatic test_valid_toggle();
        build_img(1, 0, 1'b0);
        gaps[3] = 2;
        gaps[5] = 1;
        run_image("valid_toggle");
        apply_reset("after_toggle");
    endtask

    task automatic test_reset_mid();
        build_img(2, 0, 1'b0);
        send_img(8);
        #2;
        apply_reset("reset_mid");
        build_img(3, 1, 1'b0);
        run_image("restart_after_reset");
        apply_reset("after_restart");
    endtask

    task automatic test_len_zero();
        build_img(0, 0, 1'b0);
        run_image("len_zero");
        apply_reset("after_len_zero");
    endtask

    task automatic test_max_len();
        build_img(WORD_NUM, 0, 1'b0);
        run_image("max_len");
        apply_reset("after_max_len");
    endtask

    task automatic test_back_to_back();
        build_img(8, 0, 1'b0);
        run_image("back_to_back");
        apply_reset("after_b2b");
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 8; r++) begin
            len = (r == 5) ? WORD_NUM + 1 + int'($urandom_range(0, 300)) : int'($urandom_range(1, 6));
            build_img(len, 2, 1'($urandom_range(0, 1)));
            run_image($sformatf("random%0d", r));
            apply_reset($sformatf("after_random%0d", r));
        end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        set_directed(8'hD6);
        run_image("checksum_good");
        apply_reset("after_chk_good");
        set_directed(8'hD5);
        run_image("checksum_bad");
        apply_reset("after_chk_bad");
    endtask
`endif

    initial begin
        rst_n      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2;
        apply_reset("power_on");
        test_two_words();
        test_len_overflow();
        test_valid_toggle();
        test_reset_mid();
        test_len_zero();
        test_back_to_back();
        test_max_len();
        test_random();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
